// File: rtl/tappy_pkg.sv
// Shared definitions for the tappy PS/2-style host transmit path:
// controller state encoding and frame geometry.
package tappy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    RELEASE
  } state_t;

  // Bits driven after the start bit: d0..d7, odd parity, stop.
  localparam int         FRAME_BITS = 10;
  localparam logic [3:0] LAST_IDX   = 4'(FRAME_BITS - 1);

endpackage

// File: rtl/tappy_edge.sv
// Two-flop synchronizer for an asynchronous bus line plus a falling-edge
// detector on the synchronized level. Lines idle high, so reset is high.
module tappy_edge (
  input  logic sysclk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall
);

  logic sync_p0, sync_p1, prev_p2;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= line;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign fall  = prev_p2 & ~sync_p1;

endmodule

// File: rtl/tappy_host_ctl.sv
// Host-to-device transmitter for a two-wire open-drain clk/dat bus: inhibits
// the bus, requests to send, shifts a byte out on device clocks, checks the ack.
module tappy_host_ctl
  import tappy_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       clk,
  input  logic       dat,
  output logic       clk_oe,
  output logic       dat_oe,
  input  logic       rx_busy,
  output logic       rx_en,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  logic             clk_s, clk_fall;
  logic             dat_p0, dat_p1;
  logic [7:0]       byte_q;
  logic [3:0]       idx;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       start_cnt;
  logic             handshake, inh_last, watch, tmo_hit, released;

  // Line value for frame position idx: data LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] i);
    if (i < 4'd8)       return b[i[2:0]];
    else if (i == 4'd8) return ~(^b);
    else                return 1'b1;
  endfunction

  tappy_edge u_clk_edge (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .line  (clk),
    .level (clk_s),
    .fall  (clk_fall)
  );

  // dat needs only its synchronized level, no edge detection.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      dat_p0 <= dat;
      dat_p1 <= dat_p0;
    end
  end

  assign tx_ready  = (state == IDLE) && !rx_busy && clk_s && (start_cnt == 2'd2);
  assign handshake = tx_valid && tx_ready;
  assign inh_last  = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
  assign watch     = (state inside {RTS, SEND, ACK, RELEASE});
  assign tmo_hit   = watch && !clk_fall && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign released  = clk_s && dat_p1;

  always_ff @(posedge sysclk) begin
    if (handshake) byte_q <= tx_byte;
  end

  // Holds off tx_ready for two cycles after reset so the synchronizers settle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt <= 2'd0;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      idx       <= 4'd0;
    end else begin
      if (start_cnt != 2'd2) start_cnt <= start_cnt + 2'd1;

      if (state == INHIBIT) inh_cnt <= inh_cnt + 1'b1;
      else                  inh_cnt <= '0;

      if (!watch || clk_fall) tmo_cnt <= '0;
      else if (!tmo_hit)      tmo_cnt <= tmo_cnt + 1'b1;

      if (state == RTS)
        idx <= 4'd0;
      else if (state == SEND && clk_fall && idx != LAST_IDX)
        idx <= idx + 4'd1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = INHIBIT;
      INHIBIT: if (inh_last)  state_nxt = RTS;
      RTS: begin
        if (tmo_hit)       state_nxt = IDLE;
        else if (clk_fall) state_nxt = SEND;
      end
      SEND: begin
        if (tmo_hit)                          state_nxt = IDLE;
        else if (clk_fall && idx == LAST_IDX) state_nxt = ACK;
      end
      ACK: begin
        if (tmo_hit)       state_nxt = IDLE;
        else if (clk_fall) state_nxt = dat_p1 ? IDLE : RELEASE;
      end
      RELEASE: if (released || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clk_oe  = 1'b0;
    dat_oe  = 1'b0;
    rx_en   = 1'b0;
    tx_done = 1'b0;
    tx_err  = 1'b0;
    case (state)
      IDLE:    rx_en  = 1'b1;
      INHIBIT: clk_oe = 1'b1;
      RTS: begin
        dat_oe = 1'b1;
        tx_err = tmo_hit;
      end
      SEND: begin
        dat_oe = ~frame_bit(byte_q, idx);
        tx_err = tmo_hit;
      end
      ACK: tx_err = tmo_hit || (clk_fall && dat_p1);
      RELEASE: begin
        tx_done = released;
        tx_err  = tmo_hit && !released;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tappy_host_ctl.sv
// Bench for tappy_host_ctl: a device model clocks frames and acks, a
// scoreboard of expected line bits and responses is checked as they appear.
module tb_tappy_host_ctl;

  localparam int INH       = 8;
  localparam int TMO       = 64;
  localparam int RESP_DONE = 1;
  localparam int RESP_ERR  = 2;

  logic       sysclk   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx_busy  = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_byte  = 8'h00;
  logic       clk_dev  = 1'b1;
  logic       dat_dev  = 1'b1;
  logic       clk, dat, clk_oe, dat_oe, rx_en, tx_ready, tx_done, tx_err;

  int checks    = 0;
  int errors    = 0;
  int resp_seen = 0;
  int half      = 6;
  int exp_bits[$];
  int exp_resp[$];

  // Open-drain wires: either side may pull low.
  assign clk = clk_dev & ~clk_oe;
  assign dat = dat_dev & ~dat_oe;

  always #5 sysclk = ~sysclk;

  tappy_host_ctl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .clk     (clk),
    .dat     (dat),
    .clk_oe  (clk_oe),
    .dat_oe  (dat_oe),
    .rx_busy (rx_busy),
    .rx_en   (rx_en),
    .tx_valid(tx_valid),
    .tx_byte (tx_byte),
    .tx_ready(tx_ready),
    .tx_done (tx_done),
    .tx_err  (tx_err)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference frame on the wire: start 0, data LSB first, parity making the
  // count of ones odd, stop 1, then the line released for the device ack.
  task automatic push_frame(input logic [7:0] b, input int nbits);
    int line[$];
    int ones;
    ones = 0;
    line.push_back(0);
    for (int i = 0; i < 8; i++) begin
      line.push_back(int'(b[i]));
      ones += int'(b[i]);
    end
    line.push_back((ones % 2 == 0) ? 1 : 0);
    line.push_back(1);
    line.push_back(1);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(1 - line[i]);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic dev_sample(input string name);
    int e;
    e = (exp_bits.size() > 0) ? exp_bits.pop_front() : -1;
    check(name, int'(dat_oe), e);
  endtask

  task automatic pulse(input bit do_sample);
    clk_dev = 1'b0;
    wait_n(half);
    if (do_sample) dev_sample("frame_bit");
    clk_dev = 1'b1;
    wait_n(half);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge sysclk);
      n++;
    end
    check("tx_ready_seen", int'(tx_ready), 1);
    tx_valid = 1'b1;
    tx_byte  = b;
    @(posedge sysclk);
    #1 tx_valid = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic wait_rts(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (clk_oe !== 1'b1 && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    check("inhibit_start", int'(clk_oe), 1);
    if (clk_oe !== 1'b1) return;
    n = 0;
    while (clk_oe === 1'b1 && n < 100) begin
      n++;
      @(negedge sysclk);
    end
    check("inhibit_len", n, INH);
    check("rx_en_while_owned", int'(rx_en), 0);
    wait_n(half);
    dev_sample("start_bit");
    ok = 1'b1;
  endtask

  task automatic wait_resp(input int tgt);
    int n;
    n = 0;
    while (resp_seen < tgt && n < 400) begin
      @(negedge sysclk);
      n++;
    end
    check("resp_count", resp_seen, tgt);
    wait_n(2);
  endtask

  task automatic run_device(input bit ack_ok, input int tgt);
    bit ok;
    wait_rts(ok);
    if (ok) begin
      for (int k = 0; k < 11; k++) pulse(1'b1);
      dat_dev = ack_ok ? 1'b0 : 1'b1;
      wait_n(2);
      pulse(1'b0);
      dat_dev = 1'b1;
    end
    wait_resp(tgt);
  endtask

  task automatic full_frame(input logic [7:0] b, input bit ack_ok);
    int tgt;
    tgt = resp_seen + 1;
    push_frame(b, 12);
    exp_resp.push_back(ack_ok ? RESP_DONE : RESP_ERR);
    send_byte(b);
    run_device(ack_ok, tgt);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT pulses done/err.
  initial begin
    forever begin
      @(negedge sysclk);
      if (tx_done === 1'b1 || tx_err === 1'b1) begin
        int got;
        got = (tx_done === 1'b1) ? RESP_DONE : RESP_ERR;
        check("done_err_exclusive", int'(tx_done & tx_err), 0);
        check("response", got, (exp_resp.size() > 0) ? exp_resp.pop_front() : 0);
        resp_seen++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         tgt;
    int         got;
    logic [7:0] b;

    wait_n(3);
    check("rst_clk_oe", int'(clk_oe), 0);
    check("rst_dat_oe", int'(dat_oe), 0);
    check("rst_tx_ready", int'(tx_ready), 0);
    check("rst_tx_done", int'(tx_done), 0);
    check("rst_tx_err", int'(tx_err), 0);
    check("rst_rx_en", int'(rx_en), 1);
    rst_n = 1'b1;
    @(negedge sysclk);
    check("ready_early_after_reset", int'(tx_ready), 0);

    full_frame(8'hED, 1'b1);
    full_frame(8'h00, 1'b1);
    full_frame(8'h01, 1'b1);

    // Receiver busy holds off a pending request.
    rx_busy  = 1'b1;
    tx_valid = 1'b1;
    tx_byte  = 8'hC3;
    for (int i = 0; i < 50; i++) begin
      @(negedge sysclk);
      check("busy_tx_ready", int'(tx_ready), 0);
      check("busy_clk_oe", int'(clk_oe), 0);
    end
    tgt = resp_seen + 1;
    push_frame(8'hC3, 12);
    exp_resp.push_back(RESP_DONE);
    rx_busy = 1'b0;
    #1 check("ready_after_busy", int'(tx_ready), 1);
    @(posedge sysclk);
    #1 tx_valid = 1'b0;
    check("inhibit_after_busy", int'(clk_oe), 1);
    @(negedge sysclk);
    run_device(1'b1, tgt);

    // Device stops clocking after d3: err must follow the synchronized edge
    // by TMO cycles; the edge itself is seen 2 cycles after the wire falls.
    b   = 8'h5A;
    tgt = resp_seen + 1;
    push_frame(b, 5);
    exp_resp.push_back(RESP_ERR);
    send_byte(b);
    wait_rts(ok);
    for (int k = 0; k < 3; k++) pulse(1'b1);
    clk_dev = 1'b0;
    got = -1;
    for (int n = 1; n <= TMO + 20; n++) begin
      @(negedge sysclk);
      if (n == half) begin
        dev_sample("frame_bit_d3");
        clk_dev = 1'b1;
      end
      if (tx_err === 1'b1) begin
        got = n;
        break;
      end
    end
    check("timeout_latency", got, TMO + 2);
    @(negedge sysclk);
    check("timeout_clk_oe", int'(clk_oe), 0);
    check("timeout_dat_oe", int'(dat_oe), 0);
    wait_resp(tgt);

    full_frame(8'h3C, 1'b0);

    // Reset while d5 is on the line.
    b   = 8'h00;
    push_frame(b, 7);
    send_byte(b);
    wait_rts(ok);
    for (int k = 0; k < 5; k++) pulse(1'b1);
    clk_dev = 1'b0;
    wait_n(half);
    dev_sample("frame_bit_d5");
    rst_n = 1'b0;
    #1;
    check("midrst_clk_oe", int'(clk_oe), 0);
    check("midrst_dat_oe", int'(dat_oe), 0);
    check("midrst_tx_ready", int'(tx_ready), 0);
    check("midrst_rx_en", int'(rx_en), 1);
    clk_dev = 1'b1;
    wait_n(4);
    rst_n = 1'b1;
    @(negedge sysclk);
    check("ready_early_after_midrst", int'(tx_ready), 0);
    full_frame(8'hAA, 1'b1);

    for (int r = 0; r < 8; r++) begin
      half = $urandom_range(4, 8);
      b    = 8'($urandom);
      full_frame(b, $urandom_range(0, 3) != 0);
    end

    wait_n(5);
    check("bits_left", exp_bits.size(), 0);
    check("resp_left", exp_resp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
